// File: rtl/chan_mux_rr_if.sv
`default_nettype none
// ============================================================================
// Module      : chan_mux_rr_if
// Description : Handshake bundle for chan_mux_rr. The N inputs, the select
//               controls and the single registered output share one bundle.
//               master drives the sources and consumes the output; slave is
//               the multiplexer itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface chan_mux_rr_if #(
  parameter int W = 32,
  parameter int N = 16
);
  localparam int SELW = $clog2(N);

  logic            mode;
  logic [SELW-1:0] select;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_chan;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output mode, select, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  mode, select, in_data, in_valid, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/chan_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : chan_mux_rr
// Description : N-channel, W-bit multiplexer with a one-entry registered
//               output and valid/ready handshakes. Fixed-index selection
//               (mode=0) or round-robin over the valid channels (mode=1).
// Revision    : 1.0 - initial release
// ============================================================================
module chan_mux_rr #(
  parameter int W = 32,
  parameter int N = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  chan_mux_rr_if.slave  bus
);
  localparam int SELW = $clog2(N);

  // N widened by one bit so the wrap compare in the search cannot overflow
  localparam logic [SELW:0]   c_n_ext = (SELW+1)'(N);
  localparam logic [SELW-1:0] c_last  = (SELW)'(N-1);

  logic [W-1:0]        r_out_data;
  logic [SELW-1:0]     r_out_chan;
  logic                r_out_valid;
  logic [SELW-1:0]     r_ptr;

  logic                w_load_en;
  logic [2**SELW-1:0]  w_valid_pad;
  logic                w_fix_valid;
  logic [SELW-1:0]     w_rr_grant;
  logic                w_rr_found;
  logic [SELW-1:0]     w_grant;
  logic                w_grant_valid;
  logic                w_xfer;
  logic [W-1:0]        w_grant_data;
  logic [N-1:0]        w_in_ready;

  // The output slot can take a word when empty or being drained this cycle
  assign w_load_en = !r_out_valid || bus.out_ready;

  // Zero-padded valids let an out-of-range select index safely read a 0
  assign w_valid_pad = (2**SELW)'(bus.in_valid);
  assign w_fix_valid = ({1'b0, bus.select} < c_n_ext) && w_valid_pad[bus.select];

  // Round-robin search: first valid channel starting at ptr, wrapping at N
  always_comb begin
    logic [SELW:0] v_idx;
    w_rr_grant = '0;
    w_rr_found = 1'b0;
    v_idx      = '0;
    for (int k = 0; k < N; k++) begin
      v_idx = {1'b0, r_ptr} + (SELW+1)'(k);
      if (v_idx >= c_n_ext) begin
        v_idx = v_idx - c_n_ext;
      end
      if (!w_rr_found && bus.in_valid[v_idx[SELW-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_grant = v_idx[SELW-1:0];
      end
    end
  end

  assign w_grant       = bus.mode ? w_rr_grant : bus.select;
  assign w_grant_valid = bus.mode ? w_rr_found : w_fix_valid;
  assign w_xfer        = w_load_en && w_grant_valid;

  // One-hot ready and data mux driven by the winning channel
  always_comb begin
    w_in_ready   = '0;
    w_grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant == (SELW)'(i)) begin
        w_in_ready[i] = w_xfer;
        w_grant_data  = bus.in_data[i*W +: W];
      end
    end
  end

  // Output register and round-robin pointer; ptr only moves on RR transfers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_valid <= 1'b0;
      r_ptr       <= '0;
    end else begin
      if (w_load_en) begin
        if (w_grant_valid) begin
          r_out_data  <= w_grant_data;
          r_out_chan  <= w_grant;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
      if (w_xfer && bus.mode) begin
        r_ptr <= (w_grant == c_last) ? '0 : w_grant + (SELW)'(1);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_chan  = r_out_chan;
  assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_chan_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_chan_mux_rr
// Description : Directed self-checking bench for chan_mux_rr. Instance A is
//               the default 16 x 32 configuration, instance B is 5 x 8 to
//               exercise a channel count that is not a power of two.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chan_mux_rr;
  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  chan_mux_rr_if #(.W(32), .N(16)) ifa ();
  chan_mux_rr_if #(.W(8),  .N(5))  ifb ();

  chan_mux_rr #(.W(32), .N(16)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
  chan_mux_rr #(.W(8),  .N(5))  dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Channel i of instance A carries base + i
  task automatic fill_a(input logic [31:0] base);
    for (int i = 0; i < 16; i++) ifa.in_data[i*32 +: 32] = base + 32'(i);
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    ifa.mode      = 1'b0;
    ifa.select    = '0;
    ifa.in_data   = '0;
    ifa.in_valid  = '0;
    ifa.out_ready = 1'b0;
    ifb.mode      = 1'b0;
    ifb.select    = '0;
    ifb.in_data   = '0;
    ifb.in_valid  = '0;
    ifb.out_ready = 1'b0;
    #3;
    checks++;
    if (ifa.out_valid !== 1'b0 || ifa.out_data !== 32'h0 || ifa.out_chan !== 4'd0) begin
      errors++;
      $display("FAIL reset_a: got v=%b d=%h c=%0d expected v=0 d=0 c=0",
               ifa.out_valid, ifa.out_data, ifa.out_chan);
    end
    checks++;
    if (ifb.out_valid !== 1'b0 || ifb.in_ready !== 5'b0) begin
      errors++;
      $display("FAIL reset_b: got v=%b rdy=%b expected v=0 rdy=00000", ifb.out_valid, ifb.in_ready);
    end
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_fixed_select();
    ifa.mode      = 1'b0;
    ifa.select    = 4'd5;
    fill_a(32'h1000_0000);
    ifa.in_data[5*32 +: 32] = 32'hDEADBEEF;
    ifa.in_valid  = 16'h0020;
    ifa.out_ready = 1'b1;
    #2;
    checks++;
    if (ifa.in_ready !== 16'h0020) begin
      errors++;
      $display("FAIL fixed_ready: got %h expected 0020", ifa.in_ready);
    end
    tick();
    checks++;
    if (ifa.out_valid !== 1'b1 || ifa.out_data !== 32'hDEADBEEF || ifa.out_chan !== 4'd5) begin
      errors++;
      $display("FAIL fixed_out: got v=%b d=%h c=%0d expected v=1 d=deadbeef c=5",
               ifa.out_valid, ifa.out_data, ifa.out_chan);
    end
    ifa.in_valid = 16'h0;
    tick();
    checks++;
    if (ifa.out_valid !== 1'b0 || ifa.out_data !== 32'hDEADBEEF || ifa.out_chan !== 4'd5) begin
      errors++;
      $display("FAIL fixed_drain: got v=%b d=%h c=%0d expected v=0 d=deadbeef c=5",
               ifa.out_valid, ifa.out_data, ifa.out_chan);
    end
  endtask

  task automatic test_back_pressure();
    ifa.mode      = 1'b0;
    ifa.select    = 4'd5;
    ifa.in_data[5*32 +: 32] = 32'hCAFE0001;
    ifa.in_valid  = 16'h0020;
    ifa.out_ready = 1'b1;
    tick();
    ifa.out_ready = 1'b0;
    ifa.in_data[5*32 +: 32] = 32'hCAFE0002;
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++;
      if (ifa.in_ready !== 16'h0) begin
        errors++;
        $display("FAIL stall_ready[%0d]: got %h expected 0000", c, ifa.in_ready);
      end
      tick();
      checks++;
      if (ifa.out_valid !== 1'b1 || ifa.out_data !== 32'hCAFE0001) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b d=%h expected v=1 d=cafe0001",
                 c, ifa.out_valid, ifa.out_data);
      end
    end
    ifa.out_ready = 1'b1;
    #2;
    checks++;
    if (ifa.in_ready !== 16'h0020) begin
      errors++;
      $display("FAIL release_ready: got %h expected 0020", ifa.in_ready);
    end
    tick();
    checks++;
    if (ifa.out_valid !== 1'b1 || ifa.out_data !== 32'hCAFE0002 || ifa.out_chan !== 4'd5) begin
      errors++;
      $display("FAIL release_load: got v=%b d=%h c=%0d expected v=1 d=cafe0002 c=5",
               ifa.out_valid, ifa.out_data, ifa.out_chan);
    end
    ifa.in_valid = 16'h0;
    tick();
  endtask

  task automatic test_rr_fairness();
    ifa.mode      = 1'b1;
    fill_a(32'h2000_0000);
    ifa.in_valid  = 16'hFFFF;
    ifa.out_ready = 1'b1;
    #2;
    checks++;
    if (ifa.in_ready !== 16'h0001) begin
      errors++;
      $display("FAIL rr_first_ready: got %h expected 0001", ifa.in_ready);
    end
    tick();
    for (int k = 0; k < 18; k++) begin
      checks++;
      if (ifa.out_valid !== 1'b1 || ifa.out_chan !== 4'(k % 16) ||
          ifa.out_data !== 32'h2000_0000 + 32'(k % 16)) begin
        errors++;
        $display("FAIL rr_seq[%0d]: got v=%b c=%0d d=%h expected v=1 c=%0d d=%h",
                 k, ifa.out_valid, ifa.out_chan, ifa.out_data, k % 16,
                 32'h2000_0000 + 32'(k % 16));
      end
      if (k < 17) tick();
    end
  endtask

  task automatic test_sparse_wrap();
    logic [3:0] exp_chan [3];
    exp_chan[0] = 4'd0;
    exp_chan[1] = 4'd3;
    exp_chan[2] = 4'd0;
    ifa.mode     = 1'b1;
    ifa.in_valid = 16'h2000;
    tick();
    checks++;
    if (ifa.out_chan !== 4'd13) begin
      errors++;
      $display("FAIL sparse_setup: got c=%0d expected 13", ifa.out_chan);
    end
    ifa.in_valid = 16'h0009;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (ifa.out_valid !== 1'b1 || ifa.out_chan !== exp_chan[k]) begin
        errors++;
        $display("FAIL sparse_wrap[%0d]: got v=%b c=%0d expected v=1 c=%0d",
                 k, ifa.out_valid, ifa.out_chan, exp_chan[k]);
      end
    end
    ifa.in_valid = 16'h0;
    tick();
  endtask

  task automatic test_npot();
    for (int i = 0; i < 5; i++) ifb.in_data[i*8 +: 8] = 8'hA0 + 8'(i);
    ifb.mode      = 1'b0;
    ifb.select    = 3'd6;
    ifb.in_valid  = 5'b11111;
    ifb.out_ready = 1'b1;
    #2;
    checks++;
    if (ifb.in_ready !== 5'b0) begin
      errors++;
      $display("FAIL npot_sel6_ready: got %b expected 00000", ifb.in_ready);
    end
    tick();
    checks++;
    if (ifb.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL npot_sel6_valid: got %b expected 0", ifb.out_valid);
    end
    ifb.select = 3'd7;
    #2;
    checks++;
    if (ifb.in_ready !== 5'b0) begin
      errors++;
      $display("FAIL npot_sel7_ready: got %b expected 00000", ifb.in_ready);
    end
    tick();
    checks++;
    if (ifb.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL npot_sel7_valid: got %b expected 0", ifb.out_valid);
    end
    ifb.mode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (ifb.out_valid !== 1'b1 || ifb.out_chan !== 3'(k % 5) ||
          ifb.out_data !== 8'hA0 + 8'(k % 5)) begin
        errors++;
        $display("FAIL npot_rr[%0d]: got v=%b c=%0d d=%h expected v=1 c=%0d d=%h",
                 k, ifb.out_valid, ifb.out_chan, ifb.out_data, k % 5, 8'hA0 + 8'(k % 5));
      end
    end
    ifb.in_valid = 5'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    ifa.mode      = 1'b0;
    ifa.select    = 4'd5;
    fill_a(32'h3000_0000);
    ifa.in_data[5*32 +: 32] = 32'h5555AAAA;
    ifa.in_valid  = 16'h0020;
    ifa.out_ready = 1'b1;
    tick();
    ifa.out_ready = 1'b0;
    tick();
    checks++;
    if (ifa.out_valid !== 1'b1 || ifa.out_data !== 32'h5555AAAA) begin
      errors++;
      $display("FAIL mid_setup: got v=%b d=%h expected v=1 d=5555aaaa", ifa.out_valid, ifa.out_data);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (ifa.out_valid !== 1'b0 || ifa.out_data !== 32'h0 || ifa.out_chan !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b d=%h c=%0d expected v=0 d=0 c=0",
               ifa.out_valid, ifa.out_data, ifa.out_chan);
    end
    tick();
    reset_n       = 1'b1;
    ifa.mode      = 1'b1;
    ifa.in_valid  = 16'hFFFF;
    ifa.out_ready = 1'b1;
    #2;
    checks++;
    if (ifa.in_ready !== 16'h0001) begin
      errors++;
      $display("FAIL post_reset_ready: got %h expected 0001", ifa.in_ready);
    end
    tick();
    checks++;
    if (ifa.out_valid !== 1'b1 || ifa.out_chan !== 4'd0 || ifa.out_data !== 32'h3000_0000) begin
      errors++;
      $display("FAIL post_reset_grant: got v=%b c=%0d d=%h expected v=1 c=0 d=30000000",
               ifa.out_valid, ifa.out_chan, ifa.out_data);
    end
    ifa.in_valid = 16'h0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fixed_select();
    test_back_pressure();
    test_rr_fairness();
    test_sparse_wrap();
    test_npot();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
